// File: rtl/acc_cpu_controller.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Drives shared-memory requests and the accumulator load/select/ALU controls.
module acc_cpu_controller #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    input  logic              acc_zero,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              acc_load_en,
    output logic              acc_src,
    output logic [1:0]        alu_op,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        ir,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_MEM    = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_STA = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_JMP = 4'd5;
    localparam logic [3:0] OP_JZ  = 4'd6;
    localparam logic [3:0] OP_HLT = 4'd7;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [7:0]        ir_r;
    logic              halted_r;
    logic              req_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic              src_r;
    logic [1:0]        alu_op_r;
    logic              load_op_r;

    logic [3:0]        opcode_s;
    logic [ADDR_W-1:0] operand_s;

    assign opcode_s  = ir_r[7:4];
    assign operand_s = ir_r[ADDR_W-1:0];

    function automatic logic [1:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_ADD:  alu_op_of = 2'b01;
            OP_SUB:  alu_op_of = 2'b10;
            default: alu_op_of = 2'b00;
        endcase
    endfunction

    // Sequencer state, PC/IR and all state-derived controls, registered together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_FETCH;
            pc_r      <= '0;
            ir_r      <= 8'h00;
            halted_r  <= 1'b0;
            req_r     <= 1'b1;
            we_r      <= 1'b0;
            addr_r    <= '0;
            src_r     <= 1'b0;
            alu_op_r  <= 2'b00;
            load_op_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir_r    <= mem_rdata;
                        pc_r    <= pc_r + PC_ONE;
                        req_r   <= 1'b0;
                        state_r <= ST_DECODE;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    case (opcode_s)
                        OP_HLT: begin
                            halted_r <= 1'b1;
                            state_r  <= ST_HALT;
                        end
                        OP_JMP: begin
                            pc_r    <= operand_s;
                            addr_r  <= operand_s;
                            req_r   <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                        OP_JZ: begin
                            pc_r    <= acc_zero ? operand_s : pc_r;
                            addr_r  <= acc_zero ? operand_s : pc_r;
                            req_r   <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                        OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                            addr_r    <= operand_s;
                            req_r     <= 1'b1;
                            we_r      <= (opcode_s == OP_STA);
                            load_op_r <= (opcode_s != OP_STA);
                            src_r     <= (opcode_s == OP_ADD) || (opcode_s == OP_SUB);
                            alu_op_r  <= alu_op_of(opcode_s);
                            state_r   <= ST_MEM;
                        end
                        default: begin
                            addr_r  <= pc_r;
                            req_r   <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    // Address/strobe stay put until the memory accepts the transfer.
                    if (mem_ready) begin
                        addr_r    <= pc_r;
                        we_r      <= 1'b0;
                        load_op_r <= 1'b0;
                        src_r     <= 1'b0;
                        alu_op_r  <= 2'b00;
                        state_r   <= ST_FETCH;
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    // Strobes are forced low while reset is held so a mid-transfer reset cannot write or load.
    assign mem_req     = req_r & reset_n;
    assign mem_we      = we_r & reset_n;
    assign acc_load_en = load_op_r & mem_ready & reset_n;
    assign mem_addr    = addr_r;
    assign acc_src     = src_r;
    assign alu_op      = alu_op_r;
    assign pc          = pc_r;
    assign ir          = ir_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_acc_cpu_controller.sv
// Self-checking bench for acc_cpu_controller: memory + accumulator model,
// transaction scoreboard, single-instruction vector table and multi-cycle sequences.
module tb_acc_cpu_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       acc_zero;
    logic       mem_req;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic       acc_load_en;
    logic       acc_src;
    logic [1:0] alu_op;
    logic [3:0] pc;
    logic [7:0] ir;
    logic       halted;

    logic [7:0] mem [16];
    logic [7:0] acc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] addr;
        logic       we;
        logic       ld;
        logic       src;
        logic [1:0] op;
    } xact_t;

    xact_t exp_q[$];

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] data;
        logic [7:0] acc_in;
        logic [7:0] exp_acc;
        logic [7:0] exp_mem;
        logic [3:0] exp_next;
        logic       exp_halt;
    } vec_t;

    vec_t vecs[12];

    acc_cpu_controller #(.ADDR_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .acc_zero(acc_zero), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .acc_load_en(acc_load_en), .acc_src(acc_src), .alu_op(alu_op), .pc(pc),
        .ir(ir), .halted(halted)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign acc_zero  = (acc == 8'h00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory writes and accumulator updates, as the external datapath would do them.
    always @(posedge clk) begin
        if (mem_req && mem_we && mem_ready)
            mem[mem_addr] <= acc;
        if (acc_load_en) begin
            if (!acc_src)            acc <= mem_rdata;
            else if (alu_op == 2'b01) acc <= acc + mem_rdata;
            else if (alu_op == 2'b10) acc <= acc - mem_rdata;
            else                     acc <= mem_rdata;
        end
    end

    // Scoreboard: every completed transfer must match the next expected one.
    always @(negedge clk) begin
        if (mem_req && mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xact: addr=%0d we=%0b ld=%0b", mem_addr, mem_we, acc_load_en);
            end else begin
                xact_t e;
                e = exp_q.pop_front();
                chk("xact", {23'd0, mem_addr, mem_we, acc_load_en, acc_src, alu_op}, {23'd0, e});
            end
        end
        if (acc_load_en)
            chk("ld_qualified", {31'd0, mem_req & mem_ready}, 32'd1);
    end

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    task automatic push_instr(input logic [3:0] fetch_addr, input logic [7:0] instr);
        logic [3:0] op;
        op = instr[7:4];
        exp_q.push_back({fetch_addr, 1'b0, 1'b0, 1'b0, 2'b00});
        if (is_mem_op(op))
            exp_q.push_back({instr[3:0], op == 4'd2, op != 4'd2, (op == 4'd3) || (op == 4'd4),
                             (op == 4'd3) ? 2'b01 : ((op == 4'd4) ? 2'b10 : 2'b00)});
    endtask

    task automatic do_reset(input logic [7:0] acc_init);
        chk("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        acc       = acc_init;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        cyc();
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{8'h1A, 8'h05, 8'h33, 8'h05, 8'h05, 4'd1,  1'b0};
        vecs[1]  = '{8'h3B, 8'h03, 8'h05, 8'h08, 8'h03, 4'd1,  1'b0};
        vecs[2]  = '{8'h4B, 8'h03, 8'h08, 8'h05, 8'h03, 4'd1,  1'b0};
        vecs[3]  = '{8'h2C, 8'h00, 8'h77, 8'h77, 8'h77, 4'd1,  1'b0};
        vecs[4]  = '{8'h6E, 8'h00, 8'h00, 8'h00, 8'h00, 4'd14, 1'b0};
        vecs[5]  = '{8'h6E, 8'h00, 8'h01, 8'h01, 8'h00, 4'd1,  1'b0};
        vecs[6]  = '{8'h5F, 8'h00, 8'h12, 8'h12, 8'h00, 4'd15, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 8'h12, 8'h12, 8'h00, 4'd1,  1'b0};
        vecs[8]  = '{8'h70, 8'h00, 8'h12, 8'h12, 8'h70, 4'd0,  1'b1};
        vecs[9]  = '{8'h9A, 8'h00, 8'h12, 8'h12, 8'h00, 4'd1,  1'b0};
        vecs[10] = '{8'h43, 8'h02, 8'h01, 8'hFF, 8'h02, 4'd1,  1'b0};
        vecs[11] = '{8'h10, 8'h10, 8'h33, 8'h10, 8'h10, 4'd1,  1'b0};

        reset_n   = 1'b0;
        mem_ready = 1'b0;
        acc       = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_ir", {24'd0, ir}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_ld", {31'd0, acc_load_en}, 32'd0);

        // Single-instruction vectors: run exactly the nominal latency then inspect.
        for (int v = 0; v < 12; v++) begin
            do_reset(vecs[v].acc_in);
            mem[vecs[v].instr[3:0]] = vecs[v].data;
            mem[0] = vecs[v].instr;
            push_instr(4'd0, vecs[v].instr);
            reset_n   = 1'b1;
            mem_ready = 1'b1;
            repeat (is_mem_op(vecs[v].instr[7:4]) ? 3 : 2) cyc();
            mem_ready = 1'b0;
            @(negedge clk);
            chk("vec_halted", {31'd0, halted}, {31'd0, vecs[v].exp_halt});
            chk("vec_mem_req", {31'd0, mem_req}, {31'd0, ~vecs[v].exp_halt});
            if (!vecs[v].exp_halt) begin
                chk("vec_next_addr", {28'd0, mem_addr}, {28'd0, vecs[v].exp_next});
                chk("vec_next_we", {31'd0, mem_we}, 32'd0);
            end
            chk("vec_acc", {24'd0, acc}, {24'd0, vecs[v].exp_acc});
            chk("vec_mem", {24'd0, mem[vecs[v].instr[3:0]]}, {24'd0, vecs[v].exp_mem});
        end

        // LDA, ADD, SUB program back to back.
        do_reset(8'h00);
        mem[0] = 8'h1A; mem[1] = 8'h3B; mem[2] = 8'h4B; mem[10] = 8'h05; mem[11] = 8'h03;
        push_instr(4'd0, 8'h1A);
        push_instr(4'd1, 8'h3B);
        push_instr(4'd2, 8'h4B);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        repeat (3) cyc();
        chk("prog_acc_lda", {24'd0, acc}, 32'h05);
        chk("prog_pc_lda", {28'd0, pc}, 32'd1);
        repeat (3) cyc();
        chk("prog_acc_add", {24'd0, acc}, 32'h08);
        repeat (3) cyc();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("prog_acc_sub", {24'd0, acc}, 32'h05);
        chk("prog_pc", {28'd0, pc}, 32'd3);

        // Wait states: 3 stalled cycles in FETCH and in MEM, LDA takes 9 cycles.
        do_reset(8'h33);
        mem[0] = 8'h1A; mem[10] = 8'h05;
        push_instr(4'd0, 8'h1A);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ws_f_addr", {27'd0, mem_req, mem_addr}, {27'd0, 1'b1, 4'd0});
            chk("ws_f_pc_ir", {20'd0, pc, ir}, 32'd0);
            cyc();
        end
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ws_m_addr", {26'd0, mem_req, mem_we, mem_addr}, {26'd0, 1'b1, 1'b0, 4'd10});
            chk("ws_m_ld", {31'd0, acc_load_en}, 32'd0);
            chk("ws_m_pc_ir", {20'd0, pc, ir}, {20'd0, 4'd1, 8'h1A});
            cyc();
        end
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("ws_acc", {24'd0, acc}, 32'h05);
        chk("ws_next_addr", {28'd0, mem_addr}, 32'd1);

        // JMP 15 then NOP at 15: PC wraps to 0.
        do_reset(8'h00);
        mem[0] = 8'h5F; mem[15] = 8'h00;
        push_instr(4'd0, 8'h5F);
        push_instr(4'd15, 8'h00);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        repeat (4) cyc();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("wrap_pc", {28'd0, pc}, 32'd0);
        chk("wrap_addr", {28'd0, mem_addr}, 32'd0);

        // HLT: halted stays high and no request for 20+ cycles even with mem_ready high.
        do_reset(8'h00);
        mem[0] = 8'h70;
        push_instr(4'd0, 8'h70);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        repeat (2) cyc();
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 22; i++) begin
                @(negedge clk);
                if (mem_req || !halted || acc_load_en) bad++;
            end
            chk("halt_quiet_cycles", bad, 32'd0);
        end
        chk("halt_pc", {28'd0, pc}, 32'd1);

        // Reset dropped during MEM of LDA with mem_ready high.
        do_reset(8'h33);
        mem[0] = 8'h1A; mem[10] = 8'h05;
        exp_q.push_back({4'd0, 1'b0, 1'b0, 1'b0, 2'b00});
        reset_n = 1'b1;
        mem_ready = 1'b1;
        repeat (2) cyc();
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_strobes", {29'd0, acc_load_en, mem_req, mem_we}, 32'd0);
        cyc();
        reset_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("mid_rst_fetch", {27'd0, mem_req, mem_addr}, {27'd0, 1'b1, 4'd0});
        chk("mid_rst_state", {19'd0, halted, pc, ir}, 32'd0);
        chk("mid_rst_acc", {24'd0, acc}, 32'h33);
        chk("final_queue", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_cpu_controller.md
# acc_cpu_controller

Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU. It fetches 8-bit instructions from a shared single-port memory, decodes them and drives the accumulator's load enable, source select and ALU op, plus memory read/write requests. It sits between instruction/data memory and the accumulator/ALU datapath. It is the only block that asserts `acc_load_en`.

## Interface
- `ADDR_W`, 4: memory address and PC width. The instruction operand field is `ir[ADDR_W-1:0]`; `ADDR_W` ≤ 4.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `mem_rdata`  in  8  memory read data, valid in a cycle with `mem_req & mem_ready & !mem_we`.
- `mem_ready`  in  1  memory completes the current request this cycle. Ignored while `mem_req`=0.
- `acc_zero`  in  1  accumulator output equals 0x00.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write strobe. Write data is the accumulator output, routed externally.
- `mem_addr`  out  ADDR_W  request address.
- `acc_load_en`  out  1  accumulator load enable, single-cycle pulse.
- `acc_src`  out  1  accumulator input mux: 0 = `mem_rdata`, 1 = ALU result.
- `alu_op`  out  2  ALU op: 00 pass, 01 add, 10 sub.
- `pc`  out  ADDR_W  program counter.
- `ir`  out  8  instruction register.
- `halted`  out  1  core stopped.

## Operation
- Instruction format: opcode `ir[7:4]`, operand address `ir[3:0]`.
- Opcodes:
  - 0 NOP
  - 1 LDA (acc ← mem[a])
  - 2 STA (mem[a] ← acc)
  - 3 ADD (acc ← acc + mem[a])
  - 4 SUB (acc ← acc − mem[a])
  - 5 JMP (pc ← a)
  - 6 JZ (pc ← a if `acc_zero`)
  - 7 HLT
  - 8–F execute as NOP.
- States: FETCH, DECODE, MEM, HALT. Encoding is free.
- FETCH:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - On `mem_ready`: `ir` ← `mem_rdata`, `pc` ← `pc`+1 (mod 2^ADDR_W), then → DECODE.
  - Otherwise the state holds.
- DECODE (`mem_req`=0):
  - NOP/undefined → FETCH.
  - HLT → HALT.
  - JMP: `pc` ← operand, → FETCH.
  - JZ: if `acc_zero`, `pc` ← operand; → FETCH. `acc_zero` is sampled in this cycle.
  - LDA/STA/ADD/SUB → MEM.
- MEM:
  - Drives `mem_req`=1, `mem_addr`=`ir[3:0]`, `mem_we`=1 only for STA.
  - On `mem_ready`: → FETCH. For LDA/ADD/SUB, also `acc_load_en`=1 for that cycle only, so the accumulator captures on the same edge.
  - Select per opcode: LDA `acc_src`=0, `alu_op`=00; ADD `acc_src`=1, `alu_op`=01; SUB `acc_src`=1, `alu_op`=10.
  - STA never asserts `acc_load_en`.
- HALT: `halted`=1, `mem_req`=0, `acc_load_en`=0. Only reset exits.
- Output behaviour outside the active cases:
  - `acc_src`/`alu_op` are 0 outside MEM.
  - `acc_load_en` is 0 in every state except MEM with `mem_ready`=1.
- Handshake:
  - While `mem_req`=1 and `mem_ready`=0, `mem_addr` and `mem_we` are held stable.
  - Exactly one transfer completes per request.
- Arithmetic:
  - PC increments modulo 2^ADDR_W, so 15 → 0 at the default.
  - Overflow/borrow is not detected; that is ALU responsibility.

## Timing
- Reset (`reset_n`=0 at a rising edge): state FETCH, `pc`=0, `ir`=0x00, `halted`=0. All strobes are 0 while `reset_n`=0.
- First fetch request is the first cycle after `reset_n` is sampled high.
- Latency with `mem_ready` tied 1:
  - NOP/JMP/JZ/HLT: 2 cycles.
  - LDA/STA/ADD/SUB: 3 cycles.
  - Each cycle of `mem_ready`=0 adds one cycle.
- Reset asserted mid-MEM (even with `mem_ready`=1): no `acc_load_en` and no write in that cycle. The next state is FETCH with `pc`=0.
- `mem_ready` high while `mem_req`=0 (DECODE/HALT) has no effect.
- `halted` rises in the cycle after DECODE of HLT and stays high until reset.

## Test plan
- Reset, `mem_ready`=1, mem[0]=0x1A, mem[10]=0x05:
  - `mem_req` seen at addr 0 in cycle 1, then addr 10.
  - `acc_load_en` pulses once in cycle 3 with `acc_src`=0.
  - Accumulator = 0x05, `pc`=1.
- Follow with mem[1]=0x3B, mem[11]=0x03 (ADD): `alu_op`=01, `acc_src`=1, accumulator = 0x08. Then mem[2]=0x4B (SUB): accumulator = 0x05.
- Hold `mem_ready`=0 for 3 cycles in FETCH and in MEM:
  - `mem_addr`/`mem_we` stable, `pc`/`ir` unchanged.
  - `acc_load_en` low until the `mem_ready` cycle.
  - Total LDA time = 3+6 cycles.
- JZ 0x6E:
  - With `acc_zero`=1: next fetch address 14.
  - With `acc_zero`=0: next fetch address = old `pc`+1.
  - JMP 0x5F then NOP at 15: `pc` wraps to 0.
- STA 0x2C: one `mem_req` with `mem_we`=1 at addr 12, no `acc_load_en`. Then HLT 0x70: `halted`=1, `mem_req` stays 0 for 20+ cycles.
- Drop `reset_n` in MEM of LDA with `mem_ready`=1: no `acc_load_en` pulse. After release: FETCH at addr 0, `ir`=0x00, `halted`=0.
